// File: rtl/core_prefetch_queue.sv
// core_prefetch_queue: ROM fetch front end feeding the decoder through a DEPTH-entry {pc, code} queue.
// Optional build macro CORE_PF_FAULT_EN tags fetches at or above ROM_LIMIT as faulted.
module core_prefetch_queue #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ROM_LIMIT = 32'h0001_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_en,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    input  logic                     thumb,
    input  logic                     branch,
    input  logic [ADDR_W-1:0]        branch_target,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [DATA_W-1:0]        dec_code,
    output logic [ADDR_W-1:0]        dec_pc,
    output logic                     dec_fault,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    // fetch stream state
    logic [ADDR_W-1:0] fetch_pc;
    logic              mode;
    logic              epoch;

    // request issued this cycle (valid is rom_en)
    logic [ADDR_W-1:0] req_pc;
    logic              req_thumb;
    logic              req_epoch;
    logic              req_fault;

    // request whose data is on rom_data this cycle
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_pc;
    logic              ret_thumb;
    logic              ret_epoch;
    logic              ret_fault;

    // queue storage
    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [DATA_W-1:0] mem_code  [DEPTH];
    logic              mem_fault [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_n;

    // combinational helpers
    logic              push;
    logic              pop;
    logic [CW-1:0]     count_n;
    logic [CW-1:0]     keep;
    logic [RW-1:0]     reserved;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_fault;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] align_mask;
    logic [DATA_W-1:0] push_code;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_code;
    logic              head_fault;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state: branch always forces the one-cycle redirect bubble
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = cpu_en ? RUN : IDLE;
            RUN:     state_n = cpu_en ? RUN : IDLE;
            REDIR:   state_n = cpu_en ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
        if (branch) begin
            state_n = REDIR;
        end
    end

    // queue bookkeeping; a return tagged with an old epoch is dropped
    always_comb begin
        pop      = dec_valid & dec_ready;
        push     = ret_valid & (ret_epoch == epoch);
        count_n  = q_count + CW'(push) - CW'(pop);
        keep     = q_count - CW'(pop);
        rd_ptr_n = rd_ptr + PW'(pop);
    end

    // issue decision counts the request still in flight
    always_comb begin
        reserved   = {1'b0, count_n} + RW'(rom_en);
        issue      = (state_n == RUN) && (reserved < RW'(DEPTH));
        issue_addr = {fetch_pc[ADDR_W-1:2], 2'b00};
        step       = mode ? ADDR_W'(2) : ADDR_W'(4);
        align_mask = thumb ? ~ADDR_W'(1) : ~ADDR_W'(3);
    end

`ifdef CORE_PF_FAULT_EN
    // out-of-range fetches are still issued but carry a fault tag
    always_comb begin
        issue_fault = (issue_addr >= ROM_LIMIT);
    end
`else
    logic unused_limit;
    assign unused_limit = ^ROM_LIMIT;

    // no fault detection in this build
    always_comb begin
        issue_fault = 1'b0;
    end
`endif

    // halfword select for Thumb, faulted fetches deliver zero
    always_comb begin
        push_code = rom_data;
        if (ret_fault) begin
            push_code = '0;
        end else if (ret_thumb) begin
            push_code = ret_pc[1] ? {16'h0, rom_data[31:16]}
                                  : {16'h0, rom_data[15:0]};
        end
    end

    // head after this cycle: the landing entry if the queue drains to it
    always_comb begin
        if (keep == '0) begin
            head_pc    = ret_pc;
            head_code  = push_code;
            head_fault = ret_fault;
        end else begin
            head_pc    = mem_pc[rd_ptr_n];
            head_code  = mem_code[rd_ptr_n];
            head_fault = mem_fault[rd_ptr_n];
        end
    end

    // fetch pointer, latched mode and flush epoch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            mode     <= 1'b0;
            epoch    <= 1'b0;
        end else if (branch) begin
            fetch_pc <= branch_target & align_mask;
            mode     <= thumb;
            epoch    <= ~epoch;
        end else if (issue) begin
            fetch_pc <= fetch_pc + step;
        end
    end

    // ROM request port and its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            req_pc    <= '0;
            req_thumb <= 1'b0;
            req_epoch <= 1'b0;
            req_fault <= 1'b0;
        end else begin
            rom_en <= issue;
            if (issue) begin
                rom_addr  <= issue_addr;
                req_pc    <= fetch_pc;
                req_thumb <= mode;
                req_epoch <= epoch;
                req_fault <= issue_fault;
            end
        end
    end

    // tag follows the request into its data cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid <= 1'b0;
            ret_pc    <= '0;
            ret_thumb <= 1'b0;
            ret_epoch <= 1'b0;
            ret_fault <= 1'b0;
        end else begin
            ret_valid <= rom_en;
            ret_pc    <= req_pc;
            ret_thumb <= req_thumb;
            ret_epoch <= req_epoch;
            ret_fault <= req_fault;
        end
    end

    // queue storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_code[i]  <= '0;
                mem_fault[i] <= 1'b0;
            end
        end else if (push && !branch) begin
            mem_pc[wr_ptr]    <= ret_pc;
            mem_code[wr_ptr]  <= push_code;
            mem_fault[wr_ptr] <= ret_fault;
        end
    end

    // pointers and occupancy; branch clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (branch) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(push);
            rd_ptr  <= rd_ptr_n;
            q_count <= count_n;
        end
    end

    // registered decoder view; pc and code hold while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid <= 1'b0;
            dec_code  <= '0;
            dec_pc    <= '0;
            dec_fault <= 1'b0;
        end else if (branch) begin
            dec_valid <= 1'b0;
            dec_fault <= 1'b0;
        end else begin
            dec_valid <= (count_n != '0);
            if (count_n != '0) begin
                dec_pc    <= head_pc;
                dec_code  <= head_code;
                dec_fault <= head_fault;
            end
        end
    end

endmodule
